fetch_sequencer: RTL

//  Instruction fetch controller for the program memory (active-low cs, 16-bit addr, 8-bit data, combinational read).

---
 rtl/fetch_sequencer_pkg.sv | 29 ++
 rtl/fetch_sequencer_len_decode.sv | 14 +
 rtl/fetch_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and helpers for the instruction fetch sequencer and its decoder.
package fetch_sequencer_pkg;

    // Fetch controller states.
    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StOp   = 3'd1,
        StB1   = 3'd2,
        StB2   = 3'd3,
        StHold = 3'd4
    } state_e;

    // Instruction length codes, in bytes.
    localparam logic [1:0] Len1 = 2'd1;
    localparam logic [1:0] Len2 = 2'd2;
    localparam logic [1:0] Len3 = 2'd3;

    // Instruction length is carried entirely by the two opcode MSBs.
    function automatic logic [1:0] op_len(input logic [7:0] op);
        logic [1:0] len;
        unique case (op[7:6])
            2'b00:   len = Len1;
            2'b01:   len = Len2;
            default: len = Len3;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/fetch_sequencer_len_decode.sv
// Combinational opcode -> instruction length decode, shared with the decoder.
module fetch_sequencer_len_decode
    import fetch_sequencer_pkg::*;
(
    input  logic [7:0] op_i,
    output logic [1:0] len_o
);

    // Pure lookup on the opcode class bits.
    always_comb begin
        len_o = op_len(op_i);
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: walks the PC through program memory one byte per
// cycle, assembles 1-3 byte instructions and hands them to the decoder over valid/ready.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_i,
    output logic        mem_cs_o,
    output logic [15:0] mem_addr_o,
    input  logic [7:0]  mem_data_i,
    input  logic        jmp_valid_i,
    input  logic [15:0] jmp_addr_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [7:0]  instr_op_o,
    output logic [7:0]  instr_b1_o,
    output logic [7:0]  instr_b2_o,
    output logic [1:0]  instr_len_o,
    output logic [15:0] instr_pc_o
);

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ipc_q, ipc_d;
    logic [7:0]  op_q, op_d;
    logic [7:0]  b1_q, b1_d;
    logic [7:0]  b2_q, b2_d;
    logic [1:0]  len_q, len_d;
    logic [1:0]  len_dec;

    // Length of the opcode currently on the memory bus (valid in StOp).
    fetch_sequencer_len_decode u_len_decode (
        .op_i  (mem_data_i),
        .len_o (len_dec)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a jump overrides everything, including an accept in StHold.
    always_comb begin
        state_d = state_q;
        if (jmp_valid_i) begin
            state_d = run_i ? StOp : StIdle;
        end else begin
            unique case (state_q)
                StIdle:  state_d = run_i ? StOp : StIdle;
                StOp:    state_d = (len_dec == Len1) ? StHold : StB1;
                StB1:    state_d = (len_q == Len2) ? StHold : StB2;
                StB2:    state_d = StHold;
                StHold: begin
                    if (instr_ready_i) begin
                        state_d = run_i ? StOp : StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // PC and bundle capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            ipc_q <= RESET_PC;
            op_q  <= 8'h00;
            b1_q  <= 8'h00;
            b2_q  <= 8'h00;
            len_q <= Len1;
        end else begin
            pc_q  <= pc_d;
            ipc_q <= ipc_d;
            op_q  <= op_d;
            b1_q  <= b1_d;
            b2_q  <= b2_d;
            len_q <= len_d;
        end
    end

    // Byte capture and PC advance; a jump discards whatever byte is on the bus.
    always_comb begin
        pc_d  = pc_q;
        ipc_d = ipc_q;
        op_d  = op_q;
        b1_d  = b1_q;
        b2_d  = b2_q;
        len_d = len_q;
        if (jmp_valid_i) begin
            pc_d = jmp_addr_i;
        end else begin
            unique case (state_q)
                StOp: begin
                    op_d  = mem_data_i;
                    b1_d  = 8'h00;
                    b2_d  = 8'h00;
                    len_d = len_dec;
                    ipc_d = pc_q;
                    pc_d  = pc_q + 16'd1;
                end
                StB1: begin
                    b1_d = mem_data_i;
                    pc_d = pc_q + 16'd1;
                end
                StB2: begin
                    b2_d = mem_data_i;
                    pc_d = pc_q + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs come straight from registers so the address is stable outside fetch.
    always_comb begin
        mem_cs_o      = !((state_q == StOp) || (state_q == StB1) || (state_q == StB2));
        mem_addr_o    = pc_q;
        instr_valid_o = (state_q == StHold);
        instr_op_o    = op_q;
        instr_b1_o    = b1_q;
        instr_b2_o    = b2_q;
        instr_len_o   = len_q;
        instr_pc_o    = ipc_q;
    end

endmodule
